// File: rtl/l2_cache_controller.sv
// L2 cache sequencing FSM: lookup, writeback, fill and update of the tag/MESI/LRU store.
// Optional macro CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module l2_cache_controller #(
  parameter int ADDR_BITS  = 32,
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12,
  parameter int WAYS       = 8,
  localparam int WB        = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_BITS-1:0]  req_addr,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  ds_lookup,
  output logic [INDEX_BITS-1:0] ds_index,
  output logic [TAG_BITS-1:0]   ds_tag,
  input  logic                  ds_hit,
  input  logic [WB-1:0]         ds_hit_way,
  input  logic [1:0]            ds_hit_mesi,
  input  logic [WB-1:0]         ds_victim_way,
  input  logic [TAG_BITS-1:0]   ds_victim_tag,
  input  logic                  ds_victim_dirty,
  output logic                  ds_write,
  output logic                  ds_touch,
  output logic [WB-1:0]         ds_way,
  output logic [1:0]            ds_mesi,
  output logic                  bus_req,
  output logic [1:0]            bus_op,
  output logic [ADDR_BITS-1:0]  bus_addr,
  input  logic                  bus_done,
  input  logic                  bus_shared
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
`endif
);

  localparam int LINE_BITS = TAG_BITS + INDEX_BITS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RFO  = 2'd1;
  localparam logic [1:0] OP_WBK  = 2'd2;

  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  logic [2:0]           state_q, state_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 write_q, write_d;
  logic                 hit_q, hit_d;
  logic [WB-1:0]        hit_way_q, hit_way_d;
  logic [WB-1:0]        victim_way_q, victim_way_d;
  logic [TAG_BITS-1:0]  victim_tag_q, victim_tag_d;
  logic [1:0]           mesi_q, mesi_d;

  // Byte offset within the line never reaches the storage or the bus.
  logic unused_offset;
  assign unused_offset = ^req_addr[5:0];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    line_d       = line_q;
    write_d      = write_q;
    hit_d        = hit_q;
    hit_way_d    = hit_way_q;
    victim_way_d = victim_way_q;
    victim_tag_d = victim_tag_q;
    mesi_d       = mesi_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          line_d  = req_addr[ADDR_BITS-1:6];
          write_d = req_write;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d        = ds_hit;
        hit_way_d    = ds_hit_way;
        victim_way_d = ds_victim_way;
        victim_tag_d = ds_victim_tag;
        if (ds_hit) begin
          // A write to a line without ownership must upgrade via RFO first.
          if (!write_q || ds_hit_mesi == MESI_E || ds_hit_mesi == MESI_M) state_d = S_UPDATE;
          else                                                            state_d = S_FILL;
        end else if (ds_victim_dirty) begin
          state_d = S_WB;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        if (bus_done) state_d = S_FILL;
      end
      S_FILL: begin
        if (bus_done) begin
          mesi_d  = write_q ? MESI_M : (bus_shared ? MESI_S : MESI_E);
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments and an async reset so outputs drop the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      write_q      <= 1'b0;
      hit_q        <= 1'b0;
      hit_way_q    <= '0;
      victim_way_q <= '0;
      victim_tag_q <= '0;
      mesi_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      write_q      <= write_d;
      hit_q        <= hit_d;
      hit_way_q    <= hit_way_d;
      victim_way_q <= victim_way_d;
      victim_tag_q <= victim_tag_d;
      mesi_q       <= mesi_d;
    end
  end

  assign ds_index = line_q[INDEX_BITS-1:0];
  assign ds_tag   = line_q[LINE_BITS-1:INDEX_BITS];

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    ds_lookup  = (state_q == S_LOOKUP);
    bus_req    = 1'b0;
    bus_op     = OP_READ;
    bus_addr   = '0;
    ds_touch   = 1'b0;
    ds_write   = 1'b0;
    ds_way     = '0;
    ds_mesi    = 2'd0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    case (state_q)
      S_WB: begin
        bus_req  = 1'b1;
        bus_op   = OP_WBK;
        bus_addr = {victim_tag_q, line_q[INDEX_BITS-1:0], 6'b0};
      end
      S_FILL: begin
        bus_req  = 1'b1;
        bus_op   = write_q ? OP_RFO : OP_READ;
        bus_addr = {line_q, 6'b0};
      end
      S_UPDATE: begin
        ds_touch = 1'b1;
        ds_way   = hit_q ? hit_way_q : victim_way_q;
        if (!hit_q) begin
          ds_write = 1'b1;
          ds_mesi  = mesi_q;
        end else if (write_q) begin
          ds_write = 1'b1;
          ds_mesi  = MESI_M;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    if (state_q == S_RESP) begin
      if (hit_q && hit_count_q != '1)        hit_count_d  = hit_count_q + 32'd1;
      else if (!hit_q && miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
    end
    if (state_q == S_WB && bus_done && wb_count_q != '1) wb_count_d = wb_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_l2_cache_controller.sv
// Scoreboard bench for l2_cache_controller: models the storage and bus responders,
// queues expected bus/update/response events at request time and compares them as they appear.
module tb_l2_cache_controller;
  localparam int ADDR_BITS  = 32;
  localparam int INDEX_BITS = 14;
  localparam int TAG_BITS   = 12;
  localparam int WB         = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_write = 1'b0;
  logic [ADDR_BITS-1:0]  req_addr = '0;
  logic                  resp_valid, resp_hit;
  logic                  ds_lookup;
  logic [INDEX_BITS-1:0] ds_index;
  logic [TAG_BITS-1:0]   ds_tag;
  logic                  ds_hit = 1'b0;
  logic [WB-1:0]         ds_hit_way = '0;
  logic [1:0]            ds_hit_mesi = '0;
  logic [WB-1:0]         ds_victim_way = '0;
  logic [TAG_BITS-1:0]   ds_victim_tag = '0;
  logic                  ds_victim_dirty = 1'b0;
  logic                  ds_write, ds_touch;
  logic [WB-1:0]         ds_way;
  logic [1:0]            ds_mesi;
  logic                  bus_req;
  logic [1:0]            bus_op;
  logic [ADDR_BITS-1:0]  bus_addr;
  logic                  bus_done = 1'b0;
  logic                  bus_shared = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  l2_cache_controller dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .ds_lookup(ds_lookup), .ds_index(ds_index), .ds_tag(ds_tag),
    .ds_hit(ds_hit), .ds_hit_way(ds_hit_way), .ds_hit_mesi(ds_hit_mesi),
    .ds_victim_way(ds_victim_way), .ds_victim_tag(ds_victim_tag), .ds_victim_dirty(ds_victim_dirty),
    .ds_write(ds_write), .ds_touch(ds_touch), .ds_way(ds_way), .ds_mesi(ds_mesi),
    .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_done(bus_done), .bus_shared(bus_shared)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] op; logic [31:0] addr; } bus_exp_t;
  typedef struct packed { logic wr; logic [2:0] way; logic [1:0] mesi; } upd_exp_t;
  typedef struct packed { logic hit; int cyc; } resp_exp_t;

  bus_exp_t  exp_bus[$];
  upd_exp_t  exp_upd[$];
  resp_exp_t exp_resp[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_lat = 0;
  logic cur_shared = 1'b0;
  logic bus_active = 1'b0;
  int bus_cnt = 0;
  int m_hits = 0, m_misses = 0, m_wbs = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Bus responder and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    bus_exp_t  b;
    upd_exp_t  u;
    resp_exp_t r;
    if (reset) begin
      bus_done   = 1'b0;
      bus_shared = 1'b0;
      bus_active = 1'b0;
    end else begin
      if (bus_done) begin
        bus_done   = 1'b0;
        bus_shared = 1'b0;
        bus_active = 1'b0;
      end
      if (bus_active) check("bus_held", bus_req, 1);
      if (bus_req && !bus_active) begin
        if (exp_bus.size() == 0) check("bus_unexp", bus_req, 0);
        else begin
          b = exp_bus.pop_front();
          check("bus_op", bus_op, b.op);
          check("bus_addr", bus_addr, b.addr);
        end
        bus_active = 1'b1;
        bus_cnt    = 0;
      end
      if (bus_active) begin
        if (bus_cnt == cur_lat) begin
          bus_done   = 1'b1;
          bus_shared = cur_shared;
        end
        bus_cnt++;
      end
      if (ds_touch) begin
        if (exp_upd.size() == 0) check("upd_unexp", ds_touch, 0);
        else begin
          u = exp_upd.pop_front();
          check("ds_write", ds_write, u.wr);
          check("ds_way", ds_way, u.way);
          if (u.wr) check("ds_mesi", ds_mesi, u.mesi);
        end
      end else begin
        check("ds_write_idle", ds_write, 0);
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) check("resp_unexp", resp_valid, 0);
        else begin
          r = exp_resp.pop_front();
          check("resp_hit", resp_hit, r.hit);
          check("resp_lat", cyc, r.cyc);
        end
      end
      check("ready_busy", req_ready & (bus_req | ds_touch | resp_valid | ds_lookup), 0);
    end
  end

  task automatic start_req(input logic wr, input logic [31:0] addr, input logic hit,
                           input logic [2:0] hway, input logic [1:0] hmesi,
                           input logic [2:0] vway, input logic [11:0] vtag, input logic vdirty,
                           input int lat, input logic shared);
    int n = 0;
    int nbus = 0;
    logic [31:0] line;
    logic [13:0] idx;
    line = {addr[31:6], 6'b0};
    idx  = addr[19:6];
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1);
    if (hit) begin
      if (!wr) exp_upd.push_back('{1'b0, hway, 2'd0});
      else if (hmesi == 2'd2 || hmesi == 2'd3) exp_upd.push_back('{1'b1, hway, 2'd3});
      else begin
        exp_bus.push_back('{2'd1, line});
        nbus = 1;
        exp_upd.push_back('{1'b1, hway, 2'd3});
      end
      m_hits++;
    end else begin
      if (vdirty) begin
        exp_bus.push_back('{2'd2, {vtag, idx, 6'b0}});
        nbus++;
        m_wbs++;
      end
      exp_bus.push_back('{wr ? 2'd1 : 2'd0, line});
      nbus++;
      exp_upd.push_back('{1'b1, vway, wr ? 2'd3 : (shared ? 2'd1 : 2'd2)});
      m_misses++;
    end
    ds_hit          = hit;
    ds_hit_way      = hway;
    ds_hit_mesi     = hmesi;
    ds_victim_way   = vway;
    ds_victim_tag   = vtag;
    ds_victim_dirty = vdirty;
    cur_lat         = lat;
    cur_shared      = shared;
    req_valid       = 1'b1;
    req_write       = wr;
    req_addr        = addr;
    exp_resp.push_back('{hit, cyc + 3 + nbus * (lat + 1)});
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = $urandom;
    check("ds_lookup", ds_lookup, 1);
    check("ds_index", ds_index, idx);
    check("ds_tag", ds_tag, addr[31:20]);
    check("ready_lookup", req_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_resp.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("resp_pending", exp_resp.size(), 0);
    check("bus_pending", exp_bus.size(), 0);
    check("upd_pending", exp_upd.size(), 0);
    exp_resp.delete();
    exp_bus.delete();
    exp_upd.delete();
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic hit,
                        input logic [2:0] hway, input logic [1:0] hmesi,
                        input logic [2:0] vway, input logic [11:0] vtag, input logic vdirty,
                        input int lat, input logic shared);
    start_req(wr, addr, hit, hway, hmesi, vway, vtag, vdirty, lat, shared);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_lookup", ds_lookup, 0);
    check("rst_touch", ds_touch, 0);
    check("rst_index", ds_index, 0);
    reset = 1'b0;
    @(negedge clk);

    // read hit in E
    do_req(1'b0, 32'h0000_1040, 1'b1, 3'd3, 2'd2, 3'd0, 12'h000, 1'b0, 0, 1'b0);
    // clean read miss, bus completes after 4 extra cycles, not shared
    do_req(1'b0, 32'h1234_5678, 1'b0, 3'd0, 2'd0, 3'd5, 12'h111, 1'b0, 4, 1'b0);
    // dirty write miss: writeback then RFO
    do_req(1'b1, 32'h5678_9AC4, 1'b0, 3'd0, 2'd0, 3'd2, 12'hABC, 1'b1, 1, 1'b0);
    // write hit in S: upgrade RFO with bus_done in the first cycle
    do_req(1'b1, 32'h0F0F_0F00, 1'b1, 3'd6, 2'd1, 3'd1, 12'h222, 1'b1, 0, 1'b1);
    // shared read miss with single-cycle bus
    do_req(1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0, 3'd7, 12'h333, 1'b0, 0, 1'b1);
    // write hit in M, read hit in S
    do_req(1'b1, 32'h0000_0000, 1'b1, 3'd1, 2'd3, 3'd4, 12'h444, 1'b1, 2, 1'b0);
    do_req(1'b0, 32'h8000_0040, 1'b1, 3'd7, 2'd1, 3'd0, 12'h555, 1'b1, 2, 1'b1);

    // reset in the middle of a fill
    start_req(1'b0, 32'h0012_3480, 1'b0, 3'd0, 2'd0, 3'd4, 12'h055, 1'b0, 30, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_bus", bus_req, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_bus_req", bus_req, 0);
    check("mid_rst_resp", resp_valid, 0);
    check("mid_rst_touch", ds_touch, 0);
    check("mid_rst_ready", req_ready, 1);
    exp_bus.delete();
    exp_upd.delete();
    exp_resp.delete();
    m_hits = 0;
    m_misses = 0;
    m_wbs = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    do_req(1'b0, 32'h0012_3480, 1'b1, 3'd2, 2'd2, 3'd4, 12'h055, 1'b0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_req(1'($urandom), $urandom, 1'($urandom), 3'($urandom), 2'(1 + $urandom_range(0, 2)),
             3'($urandom), 12'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
    check("wb_count", wb_count, m_wbs);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
